asg_frame_loader: RTL and testbench

Upstream feeder for the azimuth signal generator. Receives one azimuth frame (SIZE bits, one bit per microsecond) as an AXI-Stream of DW-bit words from DMA and assembles it in a back buffer. On each TRIG rising edge it swaps the completed frame onto the SIZE-bit DATA bus consumed by the generator. Raises sticky flags for underrun (trigger before a frame is ready) and framing errors (TLAST misplaced).

---
 rtl/asg_pkg.sv | 20 ++
 rtl/asg_edge_detect.sv | 22 ++
 rtl/asg_frame_loader.sv | 123 ++++++++++++
 tb/tb_asg_frame_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// Shared types and elaboration helpers for the azimuth signal generator frame path.
package asg_pkg;

    typedef enum logic {
        StFill,
        StFull
    } ld_state_e;

    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned words_of(input int unsigned size, input int unsigned dw);
        return size / dw;
    endfunction

    // A frame must be a whole, nonzero number of stream words.
    function automatic bit size_ok(input int unsigned size, input int unsigned dw);
        return (dw != 0) && (size >= dw) && ((size % dw) == 0);
    endfunction

endpackage

// File: rtl/asg_edge_detect.sv
// Rising-edge detector on an already-synchronous level; PULSE is high in the cycle where
// IN is 1 and its registered copy is still 0.
module asg_edge_detect (
    input  logic SYS_CLK,
    input  logic SYS_RESETN,
    input  logic IN,
    output logic PULSE
);

    logic in_q;

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RESETN) begin
            in_q <= 1'b0;
        end else begin
            in_q <= IN;
        end
    end

    assign PULSE = IN & ~in_q;

endmodule

// File: rtl/asg_frame_loader.sv
// Assembles one azimuth frame from an AXI-Stream into a back buffer and swaps it onto DATA
// on each TRIG rising edge; flags underrun and misplaced TLAST.
module asg_frame_loader
    import asg_pkg::*;
#(
    parameter int unsigned SIZE = 3200,
    parameter int unsigned DW   = 32
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RESETN,
    input  logic                   TRIG,
    input  logic [DW-1:0]          S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    input  logic                   CLR_ERR,
    output logic [SIZE-1:0]        DATA,
    output logic                   EN,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT,
    output logic                   UNDERRUN,
    output logic                   FRAME_ERR
);

    localparam int unsigned WORDS = words_of(SIZE, DW);
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if (!size_ok(SIZE, DW)) begin : g_bad_size
        $error("asg_frame_loader: SIZE must be a nonzero multiple of DW");
    end

    ld_state_e              state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [SIZE-1:0]        back_q;
    logic [SIZE-1:0]        data_q;
    logic                   en_q;
    logic                   tready_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   underrun_q;
    logic                   frame_err_q;

    logic trig_edge;
    logic xfer;
    logic at_last;

    asg_edge_detect u_trig_edge (
        .SYS_CLK    (SYS_CLK),
        .SYS_RESETN (SYS_RESETN),
        .IN         (TRIG),
        .PULSE      (trig_edge)
    );

    assign xfer    = S_AXIS_TVALID & tready_q;
    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RESETN) begin
            state_q     <= StFill;
            idx_q       <= '0;
            back_q      <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            tready_q    <= 1'b0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Clear first so that a same-cycle set below wins.
            if (CLR_ERR) begin
                underrun_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end

            // Words flagged as framing errors are written too; idx restarts so they get
            // overwritten by the next frame and never reach DATA.
            if (xfer) begin
                back_q[idx_q*DW +: DW] <= S_AXIS_TDATA;
            end

            unique case (state_q)
                StFill: begin
                    tready_q <= 1'b1;
                    if (xfer) begin
                        if (at_last && S_AXIS_TLAST) begin
                            state_q  <= StFull;
                            tready_q <= 1'b0;
                        end else if (at_last || S_AXIS_TLAST) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    // Generator keeps replaying the previous frame.
                    if (trig_edge) begin
                        underrun_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (trig_edge) begin
                        data_q      <= back_q;
                        en_q        <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        idx_q       <= '0;
                        state_q     <= StFill;
                        tready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign DATA          = data_q;
    assign EN            = en_q;
    assign FRAME_CNT     = frame_cnt_q;
    assign UNDERRUN      = underrun_q;
    assign FRAME_ERR     = frame_err_q;

endmodule

// File: tb/tb_asg_frame_loader.sv
// Directed bench for asg_frame_loader at default geometry (3200 bits, 32-bit words).
module tb_asg_frame_loader;

    localparam int SIZE  = 3200;
    localparam int DW    = 32;
    localparam int WORDS = SIZE / DW;

    logic            clk;
    logic            resetn;
    logic            trig;
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tlast;
    logic            tready;
    logic            clr;
    logic [SIZE-1:0] data;
    logic            en;
    logic [15:0]     cnt;
    logic            underrun;
    logic            frame_err;

    int checks = 0;
    int errors = 0;

    asg_frame_loader #(
        .SIZE (SIZE),
        .DW   (DW)
    ) dut (
        .SYS_CLK       (clk),
        .SYS_RESETN    (resetn),
        .TRIG          (trig),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .CLR_ERR       (clr),
        .DATA          (data),
        .EN            (en),
        .FRAME_CNT     (cnt),
        .UNDERRUN      (underrun),
        .FRAME_ERR     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of DATA words differing from base+k (or from 0 when zero is set).
    function automatic int bad_words(input logic [31:0] base, input bit zero);
        int n = 0;
        for (int k = 0; k < WORDS; k++) begin
            logic [31:0] exp;
            exp = zero ? 32'h0 : base + 32'(k);
            if (data[k*DW +: DW] !== exp) n++;
        end
        return n;
    endfunction

    task automatic push(input logic [31:0] d, input logic l, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!tready) begin
            check("tready_wait", tready, 1);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Pushes words [first, first+n) of a frame; TLAST on index last_at (-1 for none).
    task automatic push_words(input logic [31:0] base, input int first, input int n,
                              input int last_at, input int gapmax);
        for (int k = first; k < first + n; k++) begin
            push(base + 32'(k), (k == last_at), (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        end
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", bad_words(0, 1'b1), 0);
        check("rst_en", en, 0);
        check("rst_cnt", cnt, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_tready", tready, 0);
        resetn = 1'b1;
        check("tready_before_first_edge", tready, 0);
        @(negedge clk);
        check("tready_after_reset", tready, 1);
    endtask

    initial begin
        resetn = 1'b0;
        trig   = 1'b0;
        tdata  = '0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        clr    = 1'b0;
        do_reset();

        // Underrun in the middle of the first fill, then completion and swap.
        push_words(32'h0, 0, 50, WORDS - 1, 0);
        pulse_trig();
        check("ur_mid_fill", underrun, 1);
        check("ur_en", en, 0);
        check("ur_data_zero", bad_words(0, 1'b1), 0);
        check("ur_cnt", cnt, 0);
        push_words(32'h0, 50, 50, WORDS - 1, 0);
        check("tready_low_full", tready, 0);
        pulse_trig();
        check("swap1_en", en, 1);
        check("swap1_cnt", cnt, 1);
        check("swap1_data", bad_words(32'h0, 1'b0), 0);
        check("swap1_tready", tready, 1);
        check("swap1_underrun_sticky", underrun, 1);
        pulse_clr();
        check("clr_underrun", underrun, 0);

        // Clean back-to-back frame.
        push_words(32'h1000_0000, 0, WORDS, WORDS - 1, 0);
        check("clean_tready_low", tready, 0);
        pulse_trig();
        check("clean_cnt", cnt, 2);
        check("clean_data", bad_words(32'h1000_0000, 1'b0), 0);
        check("clean_underrun", underrun, 0);
        check("clean_frame_err", frame_err, 0);

        // Early TLAST on word 40, then a clean frame from word 0.
        push_words(32'h2000_0000, 0, 41, 40, 0);
        check("early_last_err", frame_err, 1);
        check("early_last_tready", tready, 1);
        push_words(32'h3000_0000, 0, WORDS, WORDS - 1, 0);
        pulse_trig();
        check("after_err_cnt", cnt, 3);
        check("after_err_data", bad_words(32'h3000_0000, 1'b0), 0);
        pulse_clr();
        check("clr_frame_err", frame_err, 0);

        // Missing TLAST: frame dropped, trigger underruns, DATA holds.
        push_words(32'h4000_0000, 0, WORDS, -1, 0);
        check("no_last_err", frame_err, 1);
        check("no_last_tready", tready, 1);
        pulse_trig();
        check("no_last_underrun", underrun, 1);
        check("no_last_cnt", cnt, 3);
        check("no_last_data", bad_words(32'h3000_0000, 1'b0), 0);
        pulse_clr();

        // Gappy stream, then TRIG held high for 10 cycles: one swap only.
        push_words(32'h5000_0000, 0, WORDS, WORDS - 1, 2);
        @(negedge clk);
        trig = 1'b1;
        repeat (10) @(negedge clk);
        trig = 1'b0;
        check("hold_cnt", cnt, 4);
        check("hold_data", bad_words(32'h5000_0000, 1'b0), 0);
        check("hold_underrun", underrun, 0);
        @(negedge clk);
        trig = 1'b1;
        clr  = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        clr  = 1'b0;
        check("set_beats_clr", underrun, 1);
        pulse_clr();
        check("clr_after_set", underrun, 0);

        // Reset mid-frame with a flag set.
        push_words(32'h6000_0000, 0, 60, WORDS - 1, 0);
        pulse_trig();
        check("pre_reset_underrun", underrun, 1);
        do_reset();

        // Fresh frame; final word and trigger land in the same cycle.
        push_words(32'h7000_0000, 0, WORDS - 1, WORDS - 1, 0);
        @(negedge clk);
        tdata  = 32'h7000_0000 + 32'(WORDS - 1);
        tlast  = 1'b1;
        tvalid = 1'b1;
        trig   = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        trig = 1'b0;
        check("same_cycle_underrun", underrun, 1);
        check("same_cycle_tready", tready, 0);
        check("same_cycle_cnt", cnt, 0);
        check("same_cycle_en", en, 0);
        pulse_trig();
        check("post_reset_cnt", cnt, 1);
        check("post_reset_en", en, 1);
        check("post_reset_data", bad_words(32'h7000_0000, 1'b0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
